// File: rtl/manta_boot_seq.sv
// -----------------------------------------------------------------------------
// manta_boot_seq
// Boot, flush and halt sequencer for the manta_style core.
//
// After reset the fetch PC is held at RESET_PC while NOPs are injected into ID
// (FLUSH). The register file is then optionally swept to zero through its
// write port (CLEAR). The PC is released while ID still sees NOPs (DRAIN),
// after which the core runs (RUN). In RUN a level halt request freezes the PC
// at the value captured on entry and keeps injecting NOPs (HALT). A soft
// restart request returns to FLUSH from any state.
//
// Configuration macro:
//   MANTA_BOOT_RFCLR_EN - when defined, the CLEAR sweep is built in. When
//                         undefined, FLUSH goes straight to DRAIN and the
//                         register-file write port outputs are tied to zero.
//
// Ports:
//   clk                 core clock, rising edge
//   rst_n               asynchronous active-low reset
//   restart_i           soft restart request, sampled every cycle
//   halt_req_i          level debug halt request (honoured in RUN/HALT only)
//   pc_in_i             current core PC, captured on HALT entry
//   pc_override_en_o    core PC mux selects pc_override_o
//   pc_override_o       forced PC value
//   instr_override_en_o ID instruction mux selects instr_override_o
//   instr_override_o    injected instruction (always NOP_INSTR)
//   rf_we_o             register-file write enable for the clear sweep
//   rf_waddr_o          clear sweep address
//   rf_wdata_o          clear data (always zero)
//   core_run_o          core is in normal execution
//   halted_o            core frozen by halt request
//   boot_done_o         one-cycle pulse on the first RUN cycle after boot
// -----------------------------------------------------------------------------
module manta_boot_seq #(
    parameter int                NUM_GPR      = 16,
    parameter int                DATA_W       = 16,
    parameter int                FLUSH_CYCLES = 9,
    parameter int                DRAIN_CYCLES = 1,
    parameter logic [DATA_W-1:0] RESET_PC     = 16'h0000,
    parameter logic [DATA_W-1:0] NOP_INSTR    = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       restart_i,
    input  logic                       halt_req_i,
    input  logic [DATA_W-1:0]          pc_in_i,
    output logic                       pc_override_en_o,
    output logic [DATA_W-1:0]          pc_override_o,
    output logic                       instr_override_en_o,
    output logic [DATA_W-1:0]          instr_override_o,
    output logic                       rf_we_o,
    output logic [$clog2(NUM_GPR)-1:0] rf_waddr_o,
    output logic [DATA_W-1:0]          rf_wdata_o,
    output logic                       core_run_o,
    output logic                       halted_o,
    output logic                       boot_done_o
);

    localparam int AW = $clog2(NUM_GPR);

    // One counter serves every timed state, so it is sized for the longest.
    localparam int CNT_MAX = (FLUSH_CYCLES > NUM_GPR)
                           ? ((FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES)
                           : ((NUM_GPR > DRAIN_CYCLES) ? NUM_GPR : DRAIN_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(NUM_GPR - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_CLEAR = 3'd1,
        ST_DRAIN = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   pc_cap_q, pc_cap_d;
    // Set while the current pass through DRAIN belongs to a boot, not a halt exit.
    logic                boot_path_q, boot_path_d;

    logic                pc_en_q, pc_en_d;
    logic [DATA_W-1:0]   pc_ovr_q, pc_ovr_d;
    logic                ie_q, ie_d;
    logic                we_q, we_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic                run_q, run_d;
    logic                halted_q, halted_d;
    logic                done_q, done_d;

    // Next-state, counter and capture logic, then output values for the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_cap_d    = pc_cap_q;
        boot_path_d = boot_path_q;

        if (restart_i) begin
            // Restart wins over any halt request and restarts FLUSH from zero.
            state_d     = ST_FLUSH;
            cnt_d       = '0;
            pc_cap_d    = RESET_PC;
            boot_path_d = 1'b1;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (cnt_q == FLUSH_LAST) begin
`ifdef MANTA_BOOT_RFCLR_EN
                        state_d = ST_CLEAR;
`else
                        state_d = ST_DRAIN;
`endif
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
`ifdef MANTA_BOOT_RFCLR_EN
                ST_CLEAR: begin
                    if (cnt_q == CLEAR_LAST) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
`endif
                ST_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (halt_req_i) begin
                        state_d     = ST_HALT;
                        pc_cap_d    = pc_in_i;
                        boot_path_d = 1'b0;
                    end else begin
                        state_d     = ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (!halt_req_i) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
                default: begin
                    // Unreachable encodings recover through a full boot.
                    state_d     = ST_FLUSH;
                    cnt_d       = '0;
                    pc_cap_d    = RESET_PC;
                    boot_path_d = 1'b1;
                end
            endcase
        end

        // Output values belonging to state_d; registered below.
        pc_en_d    = (state_d == ST_FLUSH) || (state_d == ST_CLEAR) || (state_d == ST_HALT);
        pc_ovr_d   = (state_d == ST_HALT) ? pc_cap_d : RESET_PC;
        ie_d       = (state_d != ST_RUN);
`ifdef MANTA_BOOT_RFCLR_EN
        we_d       = (state_d == ST_CLEAR);
        waddr_d    = (state_d == ST_CLEAR) ? cnt_d[AW-1:0] : {AW{1'b0}};
`else
        we_d       = 1'b0;
        waddr_d    = {AW{1'b0}};
`endif
        run_d      = (state_d == ST_RUN);
        halted_d   = (state_d == ST_HALT);
        // Pulse only on the DRAIN->RUN step of a boot, never on a halt exit.
        done_d     = (state_d == ST_RUN) && (state_q == ST_DRAIN) && boot_path_q;
    end

    // State, counter, captured PC and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FLUSH;
            cnt_q       <= '0;
            pc_cap_q    <= RESET_PC;
            boot_path_q <= 1'b1;
            pc_en_q     <= 1'b1;
            pc_ovr_q    <= RESET_PC;
            ie_q        <= 1'b1;
            we_q        <= 1'b0;
            waddr_q     <= {AW{1'b0}};
            run_q       <= 1'b0;
            halted_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_cap_q    <= pc_cap_d;
            boot_path_q <= boot_path_d;
            pc_en_q     <= pc_en_d;
            pc_ovr_q    <= pc_ovr_d;
            ie_q        <= ie_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            run_q       <= run_d;
            halted_q    <= halted_d;
            done_q      <= done_d;
        end
    end

    assign pc_override_en_o    = pc_en_q;
    assign pc_override_o       = pc_ovr_q;
    assign instr_override_en_o = ie_q;
    assign instr_override_o    = NOP_INSTR;
    assign rf_we_o             = we_q;
    assign rf_waddr_o          = waddr_q;
    assign rf_wdata_o          = {DATA_W{1'b0}};
    assign core_run_o          = run_q;
    assign halted_o            = halted_q;
    assign boot_done_o         = done_q;

endmodule
